// File: rtl/fifo_dd_stream_out_if.sv
// ---------------------------------------------------------------------------
// fifo_dd_stream_out_if
// Valid/ready stream carrying double-width FIFO words out of the read-side
// adapter.
//   m_data  [2*WI-1:0]  stream data      (master -> slave)
//   m_valid             stream valid     (master -> slave)
//   m_ready             consumer ready   (slave  -> master)
// ---------------------------------------------------------------------------
interface fifo_dd_stream_out_if #(
    parameter int WI = 8
) ();
    logic [2*WI-1:0] m_data;
    logic            m_valid;
    logic            m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_dd_stream_out.sv
// ---------------------------------------------------------------------------
// fifo_dd_stream_out
// Read-side adapter for the double-data-width synchronous FIFO. Issues pops
// from the FIFO empty/level flags and turns the show-ahead pop interface into
// a registered valid/ready stream through a two-entry buffer (head + skid),
// so a consumer stall never drops a word that is already being popped.
//
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   enable         0: no new pops are issued (consumer pops still proceed)
//   clear          synchronous flush, issued together with the FIFO clear
//   fifo_rdata     FIFO show-ahead data, captured on every fifo_read cycle
//   fifo_empty     FIFO empty flag
//   fifo_level     FIFO fill level in write-width words
//   fifo_read      registered FIFO pop strobe
//   m_if           stream output (master modport)
//   beat_cnt       16-bit wrapping count of stream beats
//                  (present only when FIFO_DD_STREAM_CNT_EN is defined)
//
// Occupancy FSM
//   state   | meaning
//   S_EMPTY | no word buffered, m_valid=0
//   S_ONE   | head valid
//   S_TWO   | head and skid valid
// ---------------------------------------------------------------------------
module fifo_dd_stream_out #(
    parameter int WI         = 8,
    parameter int LEVLBITS   = 5,
    parameter int SAFE_LEVEL = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                clear,
    input  logic [2*WI-1:0]     fifo_rdata,
    input  logic                fifo_empty,
    input  logic [LEVLBITS-1:0] fifo_level,
    output logic                fifo_read,
`ifdef FIFO_DD_STREAM_CNT_EN
    output logic [15:0]         beat_cnt,
`endif
    fifo_dd_stream_out_if.master m_if
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_e;

    occ_e            occ_q, occ_d;
    logic [2*WI-1:0] head_q, head_d;
    logic [2*WI-1:0] skid_q, skid_d;
    logic            fifo_read_q, fifo_read_d;

    logic            push;
    logic            pop;
    logic            m_valid_int;
    logic [2:0]      occ_cnt;
    logic [2:0]      credit_sum;
    logic            level_low;

    assign push = fifo_read_q;
    assign pop  = m_valid_int & m_if.m_ready;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q       <= S_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            fifo_read_q <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            fifo_read_q <= fifo_read_d;
        end
    end

    // next state and pop issue
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        case (occ_q)
            S_EMPTY: begin
                if (push) begin
                    occ_d  = S_ONE;
                    head_d = fifo_rdata;
                end
            end
            S_ONE: begin
                if (push && !pop) begin
                    occ_d  = S_TWO;
                    skid_d = fifo_rdata;
                end else if (push && pop) begin
                    head_d = fifo_rdata;
                end else if (pop) begin
                    occ_d  = S_EMPTY;
                end
            end
            S_TWO: begin
                // The credit rule never lets a push land here.
                if (pop) begin
                    occ_d  = S_ONE;
                    head_d = skid_q;
                end
            end
            default: occ_d = S_EMPTY;
        endcase
        if (clear) begin
            occ_d = S_EMPTY;
        end

        // Words owned after this edge: buffered + in flight - leaving.
        credit_sum = occ_cnt + {2'b00, fifo_read_q} - {2'b00, pop};
        // With a pop already in flight, a low level means the flags may not
        // yet show the word it removes; skip one cycle rather than over-read.
        level_low  = (fifo_level <= LEVLBITS'(SAFE_LEVEL));
        fifo_read_d = enable & ~clear & ~fifo_empty & (credit_sum < 3'd2)
                    & ~(fifo_read_q & level_low);
    end

    // outputs
    always_comb begin
        m_valid_int = 1'b0;
        occ_cnt     = 3'd0;
        case (occ_q)
            S_ONE: begin
                m_valid_int = 1'b1;
                occ_cnt     = 3'd1;
            end
            S_TWO: begin
                m_valid_int = 1'b1;
                occ_cnt     = 3'd2;
            end
            default: begin
                m_valid_int = 1'b0;
                occ_cnt     = 3'd0;
            end
        endcase
        m_if.m_valid = m_valid_int;
        m_if.m_data  = head_q;
        fifo_read    = fifo_read_q;
    end

`ifdef FIFO_DD_STREAM_CNT_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (clear) begin
            beat_cnt_d = '0;
        end else if (pop) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule
